// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity modes
// and the parity helper used when a byte is accepted.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txState_t;

  localparam int PARITY_NONE    = 0;
  localparam int PARITY_ODD     = 1;
  localparam int PARITY_EVEN    = 2;
  localparam int UART_DATA_BITS = 8;

  function automatic logic calcParity(input logic [UART_DATA_BITS-1:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; pulses bitDoneOUT on the last clock of
// each bit and restarts from zero whenever clearIN is high.
module uart_baud_counter #(
  parameter int CLOCKS_PER_BIT = 434
) (
  input  logic clockIN,
  input  logic nResetIN,
  input  logic clearIN,
  output logic bitDoneOUT
);

  localparam int COUNT_BITS = $clog2(CLOCKS_PER_BIT);
  localparam logic [COUNT_BITS-1:0] LAST_COUNT = COUNT_BITS'(CLOCKS_PER_BIT - 1);

  logic [COUNT_BITS-1:0] countReg;
  logic [COUNT_BITS-1:0] countNext;

  always_comb begin
    countNext = countReg + 1'b1;
    if (clearIN || (countReg == LAST_COUNT)) begin
      countNext = '0;
    end
  end

  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) begin
      countReg <= '0;
    end else begin
      countReg <= countNext;
    end
  end

  assign bitDoneOUT = (countReg == LAST_COUNT);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: valid/ready byte input, start + 8 data bits LSB first,
// optional parity, 1 or 2 stop bits, with back-to-back frames supported.
module uart_transmitter #(
  parameter int CLOCKS_PER_BIT = 434,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic       clockIN,
  input  logic       nResetIN,
  input  logic [7:0] dataIN,
  input  logic       validIN,
  output logic       readyOUT,
  output logic       txOUT,
  output logic       busyOUT
);

  import uart_pkg::*;

  localparam logic [3:0] LAST_DATA  = 4'(UART_DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
  localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);

  txState_t   stateReg, stateNext;
  logic [7:0] shiftReg, shiftNext;
  logic [3:0] bitCntReg, bitCntNext;
  logic       parityReg, parityNext;
  logic       txReg, txNext;
  logic       bitDone;
  logic       lastStop;
  logic       accept;
  logic       clearBaud;

  uart_baud_counter #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) baudCounter (
    .clockIN   (clockIN),
    .nResetIN  (nResetIN),
    .clearIN   (clearBaud),
    .bitDoneOUT(bitDone)
  );

  assign lastStop  = (stateReg == STOP) && bitDone && (bitCntReg == LAST_STOP);
  assign readyOUT  = (stateReg == IDLE) || lastStop;
  assign accept    = validIN && readyOUT;
  // Restarting the bit timer on acceptance keeps every frame phase-aligned to its own start.
  assign clearBaud = (stateReg == IDLE) || accept;

  always_comb begin
    stateNext  = stateReg;
    shiftNext  = shiftReg;
    bitCntNext = bitCntReg;
    parityNext = parityReg;

    case (stateReg)
      IDLE: begin
        if (accept) begin
          stateNext  = START;
          shiftNext  = dataIN;
          parityNext = calcParity(dataIN, PARITY);
          bitCntNext = '0;
        end
      end
      START: begin
        if (bitDone) begin
          stateNext  = DATA;
          bitCntNext = '0;
        end
      end
      DATA: begin
        if (bitDone) begin
          shiftNext = {1'b0, shiftReg[7:1]};
          if (bitCntReg == LAST_DATA) begin
            bitCntNext = '0;
            stateNext  = HAS_PARITY ? uart_pkg::PARITY : STOP;
          end else begin
            bitCntNext = bitCntReg + 1'b1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bitDone) begin
          stateNext  = STOP;
          bitCntNext = '0;
        end
      end
      STOP: begin
        if (bitDone) begin
          if (bitCntReg == LAST_STOP) begin
            bitCntNext = '0;
            if (accept) begin
              stateNext  = START;
              shiftNext  = dataIN;
              parityNext = calcParity(dataIN, PARITY);
            end else begin
              stateNext = IDLE;
            end
          end else begin
            bitCntNext = bitCntReg + 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // The line flop is loaded with the value of the state being entered.
    case (stateNext)
      START:            txNext = 1'b0;
      DATA:             txNext = shiftNext[0];
      uart_pkg::PARITY: txNext = parityNext;
      default:          txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) begin
      stateReg  <= IDLE;
      shiftReg  <= '0;
      bitCntReg <= '0;
      parityReg <= 1'b0;
      txReg     <= 1'b1;
    end else begin
      stateReg  <= stateNext;
      shiftReg  <= shiftNext;
      bitCntReg <= bitCntNext;
      parityReg <= parityNext;
      txReg     <= txNext;
    end
  end

  assign txOUT   = txReg;
  assign busyOUT = (stateReg != IDLE);

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter that accepts bytes over a valid/ready handshake and shifts them out on a single line: one start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It is the transmit counterpart of the board's receive path, which majority-filters the incoming serial line. It sits between the command/status logic of the WS2811 driver and the FPGA UART TX pin, and returns acknowledgements and status bytes to the host at a fixed baud rate derived from the system clock.

## Interface
Parameters:
- CLOCKS_PER_BIT, 434, system clocks per serial bit (50 MHz / 115200); legal range 2..65535.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clockIN  input  1  system clock; all logic is on its rising edge.
- nResetIN  input  1  asynchronous, active-low reset.
- dataIN  input  8  byte to transmit; sampled only on acceptance.
- validIN  input  1  dataIN is valid.
- readyOUT  output  1  transmitter can accept a byte this cycle.
- txOUT  output  1  serial line; idles high; registered output.
- busyOUT  output  1  a frame is in progress (any state other than IDLE).

## Operation
- Acceptance happens in any cycle where validIN and readyOUT are both high. On acceptance:
  - dataIN is latched into an 8-bit shift register.
  - Parity is computed from the latched byte.
  - The FSM enters START.
- FSM states and transitions:
  - IDLE -> START on acceptance.
  - START -> DATA.
  - DATA -> DATA, repeated until 8 bits are sent.
  - DATA -> PARITY if PARITY != 0, otherwise DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> STOP for the second stop bit when STOP_BITS = 2.
  - STOP -> IDLE, or STOP -> START directly if a byte is accepted in the final stop cycle.
- Line value per state:
  - IDLE = 1.
  - START = 0.
  - DATA = shift register bit 0; the register shifts right once per bit.
  - PARITY = parity bit.
  - STOP = 1.
- Parity bit:
  - Even: XOR of the 8 data bits.
  - Odd: inverse of that XOR.
- readyOUT is high in IDLE, and also in the last clock cycle of the final stop bit. It is low at all other times.
- Holding validIN high gives back-to-back frames with no idle gap.
- Changes to dataIN or validIN while readyOUT is low have no effect on the frame in flight.
- Bit counter width: 4 bits. Baud counter width: clog2(CLOCKS_PER_BIT).

## Timing
- Reset values: txOUT = 1, readyOUT = 1, busyOUT = 0, FSM = IDLE, all counters = 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronously). txOUT returns to 1, and the partial frame is not resumed.
- Latency: txOUT falls on the first rising edge after the acceptance cycle.
- Every bit is held for exactly CLOCKS_PER_BIT cycles.
- Frame length in cycles: CLOCKS_PER_BIT × (1 + 8 + (PARITY != 0) + STOP_BITS).
- busyOUT rises with the start bit. It falls after the final stop bit, unless a new frame starts back-to-back, in which case it stays high.
- The baud counter restarts at 0 at every bit boundary and on every acceptance. There is no phase carry-over between frames.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the parity-mode constants PARITY_NONE, PARITY_ODD and PARITY_EVEN;
  - the data width constant UART_DATA_BITS = 8.
- One natural sub-module, uart_baud_counter:
  - parameterised by CLOCKS_PER_BIT;
  - inputs: clear;
  - output: bitDoneOUT, a one-cycle pulse at count CLOCKS_PER_BIT−1.
- Top level contains the FSM, the shift register, the bit counter and the parity logic.

## Test plan
All scenarios use CLOCKS_PER_BIT = 4.
- Reset, PARITY 0: drive nResetIN low and then high → txOUT=1, readyOUT=1, busyOUT=0 throughout, with no activity.
- Send 0x55 (PARITY 0, STOP_BITS 1) → txOUT = 0,1,0,1,0,1,0,1,0,1, each value held 4 cycles. Total 40 cycles; readyOUT is high in cycle 40.
- PARITY 2, send 0xA7 → parity bit = 1. PARITY 1, send 0x00 → parity bit = 1. Both frames are 44 cycles.
- Hold validIN high with 0x01 then 0x80 (STOP_BITS 2) → two frames totalling 88 cycles, with no idle cycle between the last stop bit and the second start bit.
- Toggle dataIN and validIN mid-frame → the transmitted byte equals the byte latched at acceptance, and readyOUT stays low.
- Assert nResetIN during data bit 3 → txOUT=1 asynchronously. After release, the next byte is sent as a complete, correct frame.
